cycle_dispatch_in: RTL and testbench
====================================

Name: cycle_dispatch_in

Overview:
- Downlink counterpart of the four-FIFO round-robin uplink reader.
- Accepts one 64-bit downstream beat stream with a valid/ready handshake and distributes it in fixed-length bursts, round-robin, into four write-side FIFOs.
- Each FIFO is 64-bit in, 32-bit out; the FIFOs sit between this block and four per-channel consumers.
- Before each burst, checks the target FIFO's wrusedw and skips channels lacking room, so no FIFO ever overflows.

Parameters:
- DATA_W, 64, downstream beat and FIFO write width.
- USEDW_W, 12, width of each fifoN_wrusedw.
- FIFO_DEPTH, 4096, FIFO capacity in DATA_W words.
- BURST_LEN, 256, beats written per channel visit (>=2).
- SPACE_MARGIN, 4, extra free words required to cover write pipeline plus wrusedw latency.

Ports:
- clk  in  1  sole clock; FIFO write clocks tie to it.
- rst  in  1  synchronous reset, active-high.
- down_data  in  DATA_W  downstream beat.
- down_valid  in  1  beat present.
- down_ready  out  1  block accepts beat this cycle.
- fifo1_wrusedw..fifo4_wrusedw  in  USEDW_W each  FIFO fill level, write side.
- fifo1_wrreq..fifo4_wrreq  out  1 each  FIFO write strobe.
- fifo1_data_in..fifo4_data_in  out  DATA_W each  FIFO write data.
- cur_ch  out  2  channel currently checked or filled (0 = fifo1).
- burst_done  out  1  one-cycle pulse when the last beat of a burst is accepted.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous, active-high (rst), sampled on the clk rising edge.
- Reset values: state=CHECK, cur_ch=0, beat count=0, down_ready=0, all wrreq=0, all data_in=0, burst_done=0.
  - Reset mid-burst abandons the partial burst.
  - Beats already written stay in the FIFO; this block has no FIFO clear.
- Accept: a beat is accepted on a cycle with down_valid && down_ready.
  - down_ready is 1 iff state==BURST, decoded from registered state, with no combinational path from down_valid.
- Write latency: the beat accepted in cycle N appears as fifoK_wrreq=1 with fifoK_data_in=beat in cycle N+1.
  - K = cur_ch at acceptance. Only one wrreq is high in any cycle.
  - A channel's data_in holds its last written value while its wrreq=0.
- FSM states: CHECK and BURST.
  - CHECK, room test: room if fifo[cur_ch]_wrusedw <= FIFO_DEPTH - BURST_LEN - SPACE_MARGIN (3836 with defaults), compared unsigned at USEDW_W+1 bits.
  - CHECK with room: go to BURST next cycle; count=0.
  - CHECK with no room: cur_ch <= cur_ch+1 (wraps 3->0); stay in CHECK. Each skip costs 1 cycle.
  - BURST: each accepted beat increments count. down_valid low stalls the count, with no timeout.
  - BURST, accepted beat with count==BURST_LEN-1: burst_done=1 next cycle, cur_ch <= cur_ch+1 (wraps), state goes to CHECK.
  - Result: one bubble cycle (down_ready=0) between consecutive bursts.
- All FIFOs lacking room: the block cycles through CHECK indefinitely with down_ready=0. No beat is accepted or dropped.
- Room is evaluated only at burst start. A wrusedw change during a burst does not abort it; the margin covers it.
- Beat order is preserved within a channel. Across channels the order is strict round-robin, minus skipped channels.

Test Plan:
1. Reset; all wrusedw=0; 1024 continuous valid beats with data=index.
   - Beats 0-255 go to fifo1, 256-511 to fifo2, 512-767 to fifo3, 768-1023 to fifo4.
   - wrreq is 1 cycle after accept; down_ready=0 exactly one cycle between bursts; burst_done fires 4 times.
2. fifo2_wrusedw=3900 held, others 0; 512 beats.
   - Beats 0-255 go to fifo1, 256-511 to fifo3; fifo2_wrreq never asserts.
   - The gap between bursts is 2 cycles.
3. Boundary: fifo1_wrusedw=3836 -> burst goes to fifo1. fifo1_wrusedw=3837 -> fifo1 skipped, burst goes to fifo2.
4. All wrusedw=4000.
   - down_ready stays 0, no wrreq, cur_ch cycles 0,1,2,3,0.
   - Then drop fifo3_wrusedw to 0: the next burst lands in fifo3, and the following CHECK starts at cur_ch=3.
5. down_valid random 50% duty through a burst to fifo1.
   - Exactly 256 fifo1_wrreq pulses; data matches input order; burst_done only after the 256th accepted beat.
6. rst pulsed after 100 beats of a fifo1 burst.
   - The cycle after rst: all wrreq=0, down_ready=0, cur_ch=0.
   - After release, the next 256 accepted beats go to fifo1 starting from count 0.

Source files
------------

// File: rtl/cycle_dispatch_in.sv
// rtl/cycle_dispatch_in.sv - round-robin burst dispatcher from one beat stream into four write-side FIFOs
module cycle_dispatch_in #(
   parameter int DATA_W       = 64,
   parameter int USEDW_W      = 12,
   parameter int FIFO_DEPTH   = 4096,
   parameter int BURST_LEN    = 256,
   parameter int SPACE_MARGIN = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DATA_W-1:0]  down_data,
   input  logic               down_valid,
   output logic               down_ready,
   input  logic [USEDW_W-1:0] fifo1_wrusedw,
   input  logic [USEDW_W-1:0] fifo2_wrusedw,
   input  logic [USEDW_W-1:0] fifo3_wrusedw,
   input  logic [USEDW_W-1:0] fifo4_wrusedw,
   output logic               fifo1_wrreq,
   output logic               fifo2_wrreq,
   output logic               fifo3_wrreq,
   output logic               fifo4_wrreq,
   output logic [DATA_W-1:0]  fifo1_data_in,
   output logic [DATA_W-1:0]  fifo2_data_in,
   output logic [DATA_W-1:0]  fifo3_data_in,
   output logic [DATA_W-1:0]  fifo4_data_in,
   output logic [1:0]         cur_ch,
   output logic               burst_done
);

   typedef enum logic {CHECK, BURST} state_t;

   localparam int CNT_W = $clog2(BURST_LEN);
   // Highest fill level that still leaves room for a whole burst plus in-flight writes.
   localparam logic [USEDW_W:0]  ROOM_MAX  = (USEDW_W+1)'(FIFO_DEPTH - BURST_LEN - SPACE_MARGIN);
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);

   state_t              state, state_nxt;
   logic [1:0]          ch_q, ch_nxt;
   logic [CNT_W-1:0]    cnt_q, cnt_nxt;
   logic                accept;
   logic                last_beat;
   logic                room;
   logic [USEDW_W-1:0]  sel_usedw;
   logic [3:0]          wrreq_q;
   logic [DATA_W-1:0]   data_q [4];
   logic                done_q;

   // Ready comes purely from registered state so there is no path from down_valid.
   assign down_ready = (state == BURST);
   assign accept     = down_valid && down_ready;

   // Fill level of the channel currently under test.
   always_comb begin
      sel_usedw = fifo1_wrusedw;
      case (ch_q)
         2'd0: sel_usedw = fifo1_wrusedw;
         2'd1: sel_usedw = fifo2_wrusedw;
         2'd2: sel_usedw = fifo3_wrusedw;
         2'd3: sel_usedw = fifo4_wrusedw;
         default: sel_usedw = fifo1_wrusedw;
      endcase
   end

   assign room = ({1'b0, sel_usedw} <= ROOM_MAX);

   // Next state: skip full channels in CHECK, count beats in BURST, advance channel on the last beat.
   always_comb begin
      state_nxt = state;
      ch_nxt    = ch_q;
      cnt_nxt   = cnt_q;
      last_beat = 1'b0;
      case (state)
         CHECK: begin
            if (room) begin
               state_nxt = BURST;
               cnt_nxt   = '0;
            end else begin
               ch_nxt = ch_q + 2'd1;
            end
         end
         BURST: begin
            if (accept) begin
               if (cnt_q == LAST_BEAT) begin
                  last_beat = 1'b1;
                  state_nxt = CHECK;
                  ch_nxt    = ch_q + 2'd1;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_q + 1'b1;
               end
            end
         end
         default: state_nxt = CHECK;
      endcase
   end

   // State, channel pointer and beat counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CHECK;
         ch_q  <= 2'd0;
         cnt_q <= '0;
      end else begin
         state <= state_nxt;
         ch_q  <= ch_nxt;
         cnt_q <= cnt_nxt;
      end
   end

   // Write stage: an accepted beat is presented to its FIFO one cycle later; data holds between writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrreq_q <= 4'b0000;
         done_q  <= 1'b0;
         for (int i = 0; i < 4; i++) data_q[i] <= '0;
      end else begin
         wrreq_q <= accept ? (4'b0001 << ch_q) : 4'b0000;
         done_q  <= last_beat;
         if (accept) data_q[ch_q] <= down_data;
      end
   end

   assign fifo1_wrreq   = wrreq_q[0];
   assign fifo2_wrreq   = wrreq_q[1];
   assign fifo3_wrreq   = wrreq_q[2];
   assign fifo4_wrreq   = wrreq_q[3];
   assign fifo1_data_in = data_q[0];
   assign fifo2_data_in = data_q[1];
   assign fifo3_data_in = data_q[2];
   assign fifo4_data_in = data_q[3];
   assign cur_ch        = ch_q;
   assign burst_done    = done_q;

endmodule

// File: tb/tb_cycle_dispatch_in.sv
// tb/tb_cycle_dispatch_in.sv - directed self-checking bench for cycle_dispatch_in
module tb_cycle_dispatch_in;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] down_data = '0;
   logic        down_valid = 1'b0;
   logic        down_ready;
   logic [11:0] fifo1_wrusedw = '0, fifo2_wrusedw = '0, fifo3_wrusedw = '0, fifo4_wrusedw = '0;
   logic        fifo1_wrreq, fifo2_wrreq, fifo3_wrreq, fifo4_wrreq;
   logic [63:0] fifo1_data_in, fifo2_data_in, fifo3_data_in, fifo4_data_in;
   logic [1:0]  cur_ch;
   logic        burst_done;

   cycle_dispatch_in dut (
      .clk(clk), .rst(rst),
      .down_data(down_data), .down_valid(down_valid), .down_ready(down_ready),
      .fifo1_wrusedw(fifo1_wrusedw), .fifo2_wrusedw(fifo2_wrusedw),
      .fifo3_wrusedw(fifo3_wrusedw), .fifo4_wrusedw(fifo4_wrusedw),
      .fifo1_wrreq(fifo1_wrreq), .fifo2_wrreq(fifo2_wrreq),
      .fifo3_wrreq(fifo3_wrreq), .fifo4_wrreq(fifo4_wrreq),
      .fifo1_data_in(fifo1_data_in), .fifo2_data_in(fifo2_data_in),
      .fifo3_data_in(fifo3_data_in), .fifo4_data_in(fifo4_data_in),
      .cur_ch(cur_ch), .burst_done(burst_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [3:0]  wr;
   logic [63:0] dat [4];
   assign wr = {fifo4_wrreq, fifo3_wrreq, fifo2_wrreq, fifo1_wrreq};
   assign dat[0] = fifo1_data_in;
   assign dat[1] = fifo2_data_in;
   assign dat[2] = fifo3_data_in;
   assign dat[3] = fifo4_data_in;

   logic [1:0]  got_ch [$];
   logic [63:0] got_data [$];
   int          bd_cnt = 0;
   int          lat_err = 0;
   int          multi_err = 0;
   logic        acc_prev = 1'b0;

   // Observe writes on the falling edge, away from the active edge.
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (wr[k]) begin
            got_ch.push_back(2'(k));
            got_data.push_back(dat[k]);
         end
      end
      if ($countones(wr) > 1) multi_err++;
      if ((|wr) != acc_prev) lat_err++;
      acc_prev = down_valid && down_ready && !rst;
      if (burst_done) bd_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      else n_pass++;
   endtask

   task automatic clear_obs();
      got_ch.delete();
      got_data.delete();
      bd_cnt = 0;
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      down_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      clear_obs();
   endtask

   // Offer n beats of data base+i; optionally random 50% valid. Counts ready-low cycles once started.
   task automatic send(input string tag, input int n, input logic [63:0] base, input bit rnd,
                       input bit tail, output int bubbles);
      int i = 0;
      int tmo = 0;
      bit started = 0;
      bubbles = 0;
      while (i < n && tmo < 20000) begin
         @(posedge clk); #1;
         down_valid = rnd ? 1'($urandom_range(1)) : 1'b1;
         down_data  = base + 64'(i);
         @(negedge clk);
         if (down_valid && down_ready) begin
            i++;
            started = 1;
         end else if (started && down_valid && !down_ready) begin
            bubbles++;
         end
         tmo++;
      end
      check({tag, " accepted"}, 64'(i), 64'(n));
      if (tail) begin
         @(posedge clk); #1;
         down_valid = 1'b0;
         @(negedge clk);
         @(negedge clk);
      end
   endtask

   // Compare observed writes with data base+i routed to channel map[burst index].
   task automatic verify(input string tag, input int n, input logic [63:0] base, input logic [7:0] map);
      int errs = 0;
      logic [1:0] exp_ch;
      check({tag, " writes"}, 64'(got_ch.size()), 64'(n));
      for (int i = 0; i < got_ch.size() && i < n; i++) begin
         exp_ch = map[2*(i/256) +: 2];
         if (got_data[i] !== base + 64'(i) || got_ch[i] !== exp_ch) begin
            if (errs == 0)
               $display("FAIL %s first bad beat %0d: ch %0d data %0d, expected ch %0d data %0d",
                        tag, i, got_ch[i], got_data[i], exp_ch, base + 64'(i));
            errs++;
         end
      end
      check({tag, " route errors"}, 64'(errs), 64'd0);
   endtask

   initial begin
      int bub;
      int obs_err;

      // 1: reset state, then four full bursts in round-robin order
      apply_reset();
      @(negedge clk);
      check("rst down_ready", 64'(down_ready), 64'd0);
      check("rst wrreq", 64'(wr), 64'd0);
      check("rst cur_ch", 64'(cur_ch), 64'd0);
      check("rst burst_done", 64'(burst_done), 64'd0);
      check("rst data_in", dat[0] | dat[1] | dat[2] | dat[3], 64'd0);
      send("t1", 1024, 64'd0, 1'b0, 1'b1, bub);
      verify("t1", 1024, 64'd0, 8'b11_10_01_00);
      check("t1 bubbles", 64'(bub), 64'd3);
      check("t1 burst_done", 64'(bd_cnt), 64'd4);

      // 2: fifo2 full is skipped at a cost of one extra cycle
      apply_reset();
      fifo2_wrusedw = 12'd3900;
      send("t2", 512, 64'h1000, 1'b0, 1'b1, bub);
      verify("t2", 512, 64'h1000, 8'b00_00_10_00);
      check("t2 bubbles", 64'(bub), 64'd2);
      check("t2 burst_done", 64'(bd_cnt), 64'd2);
      fifo2_wrusedw = '0;

      // 3: room threshold boundary
      apply_reset();
      fifo1_wrusedw = 12'd3836;
      send("t3a", 256, 64'h2000, 1'b0, 1'b1, bub);
      verify("t3a", 256, 64'h2000, 8'h00);
      apply_reset();
      fifo1_wrusedw = 12'd3837;
      send("t3b", 256, 64'h3000, 1'b0, 1'b1, bub);
      verify("t3b", 256, 64'h3000, 8'h01);
      fifo1_wrusedw = '0;

      // 4: all full -> channel pointer spins, nothing accepted; then fifo3 frees up
      fifo1_wrusedw = 12'd4000; fifo2_wrusedw = 12'd4000;
      fifo3_wrusedw = 12'd4000; fifo4_wrusedw = 12'd4000;
      apply_reset();
      down_valid = 1'b1;
      down_data  = 64'h4000;
      obs_err = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("t4 cur_ch step %0d", c), 64'(cur_ch), 64'(c % 4));
         if (down_ready || (|wr)) obs_err++;
      end
      check("t4 idle activity", 64'(obs_err), 64'd0);
      fifo3_wrusedw = '0;
      send("t4", 256, 64'h4000, 1'b0, 1'b0, bub);
      @(negedge clk);
      check("t4 next cur_ch", 64'(cur_ch), 64'd3);
      check("t4 burst_done", 64'(burst_done), 64'd1);
      @(posedge clk); #1;
      down_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      verify("t4", 256, 64'h4000, 8'h02);
      fifo1_wrusedw = '0; fifo2_wrusedw = '0; fifo4_wrusedw = '0;

      // 5: 50% valid duty through one fifo1 burst
      apply_reset();
      send("t5", 256, 64'h5000, 1'b1, 1'b0, bub);
      check("t5 done early", 64'(bd_cnt), 64'd0);
      @(negedge clk);
      check("t5 burst_done", 64'(burst_done), 64'd1);
      @(posedge clk); #1;
      down_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      verify("t5", 256, 64'h5000, 8'h00);

      // 6: reset mid-burst with a beat pending
      apply_reset();
      send("t6a", 100, 64'h6000, 1'b0, 1'b0, bub);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("t6 rst wrreq", 64'(wr), 64'd0);
      check("t6 rst down_ready", 64'(down_ready), 64'd0);
      check("t6 rst cur_ch", 64'(cur_ch), 64'd0);
      verify("t6a", 100, 64'h6000, 8'h00);
      @(posedge clk); #1;
      rst = 1'b0;
      down_valid = 1'b0;
      clear_obs();
      send("t6b", 256, 64'h7000, 1'b0, 1'b1, bub);
      verify("t6b", 256, 64'h7000, 8'h00);
      check("t6 burst_done", 64'(bd_cnt), 64'd1);

      check("one-hot wrreq", 64'(multi_err), 64'd0);
      check("write latency", 64'(lat_err), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
